// File: rtl/dot_fp_pkg.sv
// dot_fp_pkg: shared accumulator FSM states and scale-range helpers.
package dot_fp_pkg;
  typedef enum logic {ACC, OUT} acc_state_t;
  localparam int scale_width_d = 8;
  function automatic int scale_max(int w);
    return 2 ** (w - 1) - 1;
  endfunction
  function automatic int scale_min(int w);
    return -(2 ** (w - 1));
  endfunction
endpackage

// File: rtl/dot_accum_fp_if.sv
// dot_accum_fp_if: beat input and result output handshakes of the accumulator.
interface dot_accum_fp_if #(
  parameter int dp_width = 19,
  parameter int scale_width = 8,
  parameter int acc_width = 24,
  parameter int cnt_width = 8
);
  logic i_valid, o_ready, i_last, o_valid, i_ready, o_ovf;
  logic signed [dp_width-1:0] i_dp;
  logic signed [scale_width-1:0] i_scale, o_scale;
  logic signed [acc_width-1:0] o_acc;
  logic [cnt_width-1:0] o_count;
  modport slave (
    input i_valid, i_dp, i_scale, i_last, i_ready,
    output o_ready, o_valid, o_acc, o_scale, o_count, o_ovf
  );
  modport master (
    output i_valid, i_dp, i_scale, i_last, i_ready,
    input o_ready, o_valid, o_acc, o_scale, o_count, o_ovf
  );
endinterface

// File: rtl/dot_accum_fp_align_add.sv
// acc_align_add: aligns a scaled operand to the running sum, adds, and renormalises on overflow.
module acc_align_add import dot_fp_pkg::*; #(
  parameter int dp_width = 19,
  parameter int scale_width = 8,
  parameter int acc_width = 24
) (
  input  logic signed [acc_width-1:0]   acc,
  input  logic signed [scale_width-1:0] scale,
  input  logic signed [dp_width-1:0]    operand,
  input  logic signed [scale_width-1:0] op_scale,
  input  logic                          empty,
  output logic signed [acc_width-1:0]   sum,
  output logic signed [scale_width-1:0] sum_scale,
  output logic                          sat
);
  localparam logic signed [scale_width-1:0] s_max = scale_width'(scale_max(scale_width));
  logic signed [acc_width-1:0] opnd, a, b;
  logic signed [scale_width:0] d;
  logic [scale_width:0] sh;
  logic signed [scale_width-1:0] rs;
  logic signed [acc_width:0] s;
  logic up, keep_op, norm;
  always_comb begin
    opnd = acc_width'(operand);
    d = (scale_width+1)'(op_scale) - (scale_width+1)'(scale);
    up = !d[scale_width] && d != '0;
    sh = up ? d : -d;
    keep_op = empty || acc == '0 || up;
    a = (empty || acc == '0) ? '0 : up ? acc >>> sh : acc;
    b = keep_op ? opnd : opnd >>> sh;
    rs = keep_op ? op_scale : scale;
    s = (acc_width+1)'(a) + (acc_width+1)'(b);
    norm = s[acc_width] ^ s[acc_width-1];
    sat = norm && rs == s_max;
    sum = norm ? s[acc_width:1] : s[acc_width-1:0];
    sum_scale = (norm && !sat) ? rs + scale_width'(1) : rs;
  end
endmodule

// File: rtl/dot_accum_fp.sv
// dot_accum_fp: accumulates (dot product, scale) beats of a vector into one normalised
// (value, scale) result and holds it under a valid/ready handshake.
module dot_accum_fp import dot_fp_pkg::*; #(
  parameter int dp_width = 19,
  parameter int scale_width = scale_width_d,
  parameter int acc_width = 24,
  parameter int cnt_width = 8
) (
  input logic i_clk,
  input logic i_rst_n,
  dot_accum_fp_if.slave bus
);
  acc_state_t state;
  logic signed [acc_width-1:0] acc, sum;
  logic signed [scale_width-1:0] scale, sum_scale;
  logic [cnt_width-1:0] cnt, cnt_n;
  logic ovf, empty, sat;
  assign cnt_n = empty ? cnt_width'(1) : &cnt ? cnt : cnt + cnt_width'(1);
  acc_align_add #(.dp_width(dp_width), .scale_width(scale_width), .acc_width(acc_width)) u_add (
    .acc(acc), .scale(scale), .operand(bus.i_dp), .op_scale(bus.i_scale), .empty(empty),
    .sum(sum), .sum_scale(sum_scale), .sat(sat)
  );
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      state <= ACC;
      acc <= '0;
      scale <= '0;
      cnt <= '0;
      ovf <= 1'b0;
      empty <= 1'b1;
      bus.o_ready <= 1'b1;
      bus.o_valid <= 1'b0;
      bus.o_acc <= '0;
      bus.o_scale <= '0;
      bus.o_count <= '0;
      bus.o_ovf <= 1'b0;
    end else if (state == ACC) begin
      if (bus.i_valid) begin
        acc <= sum;
        scale <= sum_scale;
        cnt <= cnt_n;
        ovf <= ovf | sat;
        empty <= 1'b0;
        if (bus.i_last) begin
          state <= OUT;
          bus.o_ready <= 1'b0;
          bus.o_valid <= 1'b1;
          bus.o_acc <= sum;
          bus.o_scale <= sum_scale;
          bus.o_count <= cnt_n;
          bus.o_ovf <= ovf | sat;
        end
      end
    end else if (bus.i_ready) begin
      state <= ACC;
      acc <= '0;
      ovf <= 1'b0;
      empty <= 1'b1;
      bus.o_ready <= 1'b1;
      bus.o_valid <= 1'b0;
      bus.o_ovf <= 1'b0;
    end
endmodule
